// File: rtl/states_pkg.sv
// Shared core encodings: core FSM states, opcodes, ALU selects and the decoded control bundle.
// The ALU imports alu_op_t from here so both ends agree on the select encoding.
package states_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned IMM_W      = 8;

    typedef enum logic [2:0] {
        CoreIdle    = 3'b000,
        CoreFetch   = 3'b001,
        CoreDecode  = 3'b010,
        CoreRequest = 3'b011,
        CoreWait    = 3'b100,
        CoreExecute = 3'b101,
        CoreUpdate  = 3'b110,
        CoreDone    = 3'b111
    } core_state_t;

    typedef enum logic [3:0] {
        OpNop   = 4'b0000,
        OpBrnzp = 4'b0001,
        OpCmp   = 4'b0010,
        OpAdd   = 4'b0011,
        OpSub   = 4'b0100,
        OpMul   = 4'b0101,
        OpDiv   = 4'b0110,
        OpLdr   = 4'b0111,
        OpStr   = 4'b1000,
        OpConst = 4'b1001,
        OpRet   = 4'b1111
    } opcode_t;

    typedef enum logic [1:0] {
        AluAdd = 2'b00,
        AluSub = 2'b01,
        AluMul = 2'b10,
        AluDiv = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        RegInAlu       = 2'b00,
        RegInMemory    = 2'b01,
        RegInImmediate = 2'b10
    } reg_input_mux_t;

    typedef struct packed {
        logic           reg_write_enable;
        logic           mem_read_enable;
        logic           mem_write_enable;
        logic           nzp_write_enable;
        reg_input_mux_t reg_input_mux;
        alu_op_t        alu_arithmetic_mux;
        logic           alu_output_mux;
        logic           pc_mux;
        logic           ret;
    } ctrl_t;

    // Unlisted opcodes (1010-1110) fall through to the all-zero NOP bundle.
    function automatic ctrl_t decode_ctrl(input logic [3:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OpBrnzp: c.pc_mux = 1'b1;
            OpCmp: begin
                c.alu_output_mux   = 1'b1;
                c.nzp_write_enable = 1'b1;
            end
            OpAdd, OpSub, OpMul, OpDiv: begin
                c.reg_write_enable   = 1'b1;
                c.reg_input_mux      = RegInAlu;
                c.alu_arithmetic_mux = alu_op_t'(opcode[1:0] + 2'd1);
            end
            OpLdr: begin
                c.reg_write_enable = 1'b1;
                c.reg_input_mux    = RegInMemory;
                c.mem_read_enable  = 1'b1;
            end
            OpStr: c.mem_write_enable = 1'b1;
            OpConst: begin
                c.reg_write_enable = 1'b1;
                c.reg_input_mux    = RegInImmediate;
            end
            OpRet: c.ret = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_illegal(input logic [3:0] opcode);
        return (opcode >= 4'hA) && (opcode <= 4'hE);
    endfunction

endpackage

// File: rtl/instruction_decoder_if.sv
// Decoder bus: core state and fetched instruction in, registered control fields out.
interface instruction_decoder_if;
    import states_pkg::*;

    logic [2:0]            core_state;
    logic [INSTR_W-1:0]    instruction;
    logic [REG_ADDR_W-1:0] decoded_rd_address;
    logic [REG_ADDR_W-1:0] decoded_rs_address;
    logic [REG_ADDR_W-1:0] decoded_rt_address;
    logic [2:0]            decoded_nzp;
    logic [IMM_W-1:0]      decoded_immediate;
    logic                  decoded_reg_write_enable;
    logic                  decoded_mem_read_enable;
    logic                  decoded_mem_write_enable;
    logic                  decoded_nzp_write_enable;
    logic [1:0]            decoded_reg_input_mux;
    logic [1:0]            decoded_alu_arithmetic_mux;
    logic                  decoded_alu_output_mux;
    logic                  decoded_pc_mux;
    logic                  decoded_ret;
    logic                  decoded_valid;
    logic                  illegal_pulse;
    logic                  illegal_sticky;

    modport master (
        output core_state, instruction,
        input  decoded_rd_address, decoded_rs_address, decoded_rt_address, decoded_nzp,
               decoded_immediate, decoded_reg_write_enable, decoded_mem_read_enable,
               decoded_mem_write_enable, decoded_nzp_write_enable, decoded_reg_input_mux,
               decoded_alu_arithmetic_mux, decoded_alu_output_mux, decoded_pc_mux, decoded_ret,
               decoded_valid, illegal_pulse, illegal_sticky
    );

    modport slave (
        input  core_state, instruction,
        output decoded_rd_address, decoded_rs_address, decoded_rt_address, decoded_nzp,
               decoded_immediate, decoded_reg_write_enable, decoded_mem_read_enable,
               decoded_mem_write_enable, decoded_nzp_write_enable, decoded_reg_input_mux,
               decoded_alu_arithmetic_mux, decoded_alu_output_mux, decoded_pc_mux, decoded_ret,
               decoded_valid, illegal_pulse, illegal_sticky
    );

endinterface

// File: rtl/instruction_decoder.sv
// Registered instruction decoder: captures the instruction on every DECODE edge and holds
// all fields until the next one. No combinational path from instruction to any output.
module instruction_decoder
    import states_pkg::*;
(
    input logic                   clk,
    input logic                   reset,
    instruction_decoder_if.slave  bus
);

    logic        capture;
    logic        illegal_d;
    ctrl_t       ctrl_d, ctrl_q;
    logic [11:0] fields_q;
    logic        valid_q, pulse_q, sticky_q;

    always_comb begin
        capture   = (bus.core_state == CoreDecode);
        ctrl_d    = decode_ctrl(bus.instruction[15:12]);
        illegal_d = is_illegal(bus.instruction[15:12]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fields_q <= '0;
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            // Pulse is rebuilt every edge so it drops on any non-capturing cycle.
            pulse_q <= capture & illegal_d;
            if (capture) begin
                fields_q <= bus.instruction[11:0];
                ctrl_q   <= ctrl_d;
                valid_q  <= 1'b1;
                sticky_q <= sticky_q | illegal_d;
            end
        end
    end

    assign bus.decoded_rd_address         = fields_q[11:8];
    assign bus.decoded_rs_address         = fields_q[7:4];
    assign bus.decoded_rt_address         = fields_q[3:0];
    assign bus.decoded_nzp                = fields_q[11:9];
    assign bus.decoded_immediate          = fields_q[7:0];
    assign bus.decoded_reg_write_enable   = ctrl_q.reg_write_enable;
    assign bus.decoded_mem_read_enable    = ctrl_q.mem_read_enable;
    assign bus.decoded_mem_write_enable   = ctrl_q.mem_write_enable;
    assign bus.decoded_nzp_write_enable   = ctrl_q.nzp_write_enable;
    assign bus.decoded_reg_input_mux      = ctrl_q.reg_input_mux;
    assign bus.decoded_alu_arithmetic_mux = ctrl_q.alu_arithmetic_mux;
    assign bus.decoded_alu_output_mux     = ctrl_q.alu_output_mux;
    assign bus.decoded_pc_mux             = ctrl_q.pc_mux;
    assign bus.decoded_ret                = ctrl_q.ret;
    assign bus.decoded_valid              = valid_q;
    assign bus.illegal_pulse              = pulse_q;
    assign bus.illegal_sticky             = sticky_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: directed vector table, then random traffic vs a table model.
module tb_instruction_decoder;

    logic clk;
    logic reset;

    instruction_decoder_if bus ();

    instruction_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic        rst;
        logic [2:0]  st;
        logic [15:0] instr;
        logic [36:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Model control word per opcode:
    // [11]regw [10]memr [9]memw [8]nzpw [7:6]inmux [5:4]arith [3]outmux [2]pc [1]ret [0]illegal
    logic [11:0] ctl_tbl [16];
    logic [15:0] m_instr;
    logic [11:0] m_ctl;
    logic        m_valid, m_pulse, m_sticky;

    function automatic logic [36:0] ev(input logic [15:0] f, input logic regw, input logic memr,
                                       input logic memw, input logic nzpw, input logic [1:0] inmux,
                                       input logic [1:0] arith, input logic outmux,
                                       input logic pc, input logic ret, input logic valid,
                                       input logic pulse, input logic sticky);
        return {f[11:8], f[7:4], f[3:0], f[11:9], f[7:0], regw, memr, memw, nzpw, inmux, arith,
                outmux, pc, ret, valid, pulse, sticky};
    endfunction

    function automatic logic [36:0] observed();
        return {bus.decoded_rd_address, bus.decoded_rs_address, bus.decoded_rt_address,
                bus.decoded_nzp, bus.decoded_immediate, bus.decoded_reg_write_enable,
                bus.decoded_mem_read_enable, bus.decoded_mem_write_enable,
                bus.decoded_nzp_write_enable, bus.decoded_reg_input_mux,
                bus.decoded_alu_arithmetic_mux, bus.decoded_alu_output_mux, bus.decoded_pc_mux,
                bus.decoded_ret, bus.decoded_valid, bus.illegal_pulse, bus.illegal_sticky};
    endfunction

    function automatic logic [36:0] model_out();
        return {m_instr[11:8], m_instr[7:4], m_instr[3:0], m_instr[11:9], m_instr[7:0],
                m_ctl[11:1], m_valid, m_pulse, m_sticky};
    endfunction

    task automatic model_step(input logic r, input logic [2:0] s, input logic [15:0] i);
        if (r) begin
            m_instr = '0; m_ctl = '0; m_valid = 0; m_pulse = 0; m_sticky = 0;
        end else if (s == 3'b010) begin
            m_instr  = i;
            m_ctl    = ctl_tbl[i[15:12]];
            m_valid  = 1;
            m_pulse  = m_ctl[0];
            m_sticky = m_sticky | m_ctl[0];
        end else begin
            m_pulse = 0;
        end
    endtask

    task automatic check(input string name, input logic [36:0] got, input logic [36:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, then sample 1 ns later.
    task automatic cycle(input logic r, input logic [2:0] s, input logic [15:0] i);
        reset           = r;
        bus.core_state  = s;
        bus.instruction = i;
        @(posedge clk);
        model_step(r, s, i);
        #1;
    endtask

    task automatic add(input logic r, input logic [2:0] s, input logic [15:0] i,
                       input logic [36:0] e, input string n);
        vec_t v;
        v.rst = r; v.st = s; v.instr = i; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        ctl_tbl[0]  = 12'h000; ctl_tbl[1]  = 12'h004; ctl_tbl[2]  = 12'h108;
        ctl_tbl[3]  = 12'h800; ctl_tbl[4]  = 12'h810; ctl_tbl[5]  = 12'h820;
        ctl_tbl[6]  = 12'h830; ctl_tbl[7]  = 12'hC40; ctl_tbl[8]  = 12'h200;
        ctl_tbl[9]  = 12'h880; ctl_tbl[15] = 12'h002;
        for (int k = 10; k <= 14; k++) ctl_tbl[k] = 12'h001;
        m_instr = '0; m_ctl = '0; m_valid = 0; m_pulse = 0; m_sticky = 0;

        //                            f        rw mr mw nw im ar om pc rt v  p  s
        add(1, 3'd1, 16'h3123, 37'h0, "reset");
        add(0, 3'd1, 16'h3123, 37'h0, "fetch_hold0");
        add(0, 3'd1, 16'h3123, 37'h0, "fetch_hold1");
        add(0, 3'd2, 16'h3123, ev(16'h3123, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "add");
        add(0, 3'd5, 16'hFFFF, ev(16'h3123, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "hold_exec");
        add(0, 3'd6, 16'hFFFF, ev(16'h3123, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "hold_upd");
        add(0, 3'd2, 16'h2012, ev(16'h2012, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0), "cmp");
        add(0, 3'd2, 16'h6456, ev(16'h6456, 1, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0), "div");
        add(0, 3'd1, 16'h9A55, ev(16'h6456, 1, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0), "hold_fetch");
        add(0, 3'd2, 16'h9A55, ev(16'h9A55, 1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0), "const");
        add(0, 3'd2, 16'h1407, ev(16'h1407, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), "brnzp");
        add(0, 3'd2, 16'h7ABC, ev(16'h7ABC, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0), "ldr");
        add(0, 3'd2, 16'h8ABC, ev(16'h8ABC, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0), "str");
        add(0, 3'd2, 16'h4321, ev(16'h4321, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), "sub");
        add(0, 3'd2, 16'h5321, ev(16'h5321, 1, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0), "mul");
        add(0, 3'd2, 16'h0ABC, ev(16'h0ABC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "nop");
        add(0, 3'd2, 16'hB000, ev(16'hB000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "illegal");
        add(0, 3'd1, 16'hB000, ev(16'hB000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "pulse_drop");
        add(0, 3'd2, 16'hE0FF, ev(16'hE0FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "illegal_e");
        add(0, 3'd2, 16'hE0FF, ev(16'hE0FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "repulse");
        add(0, 3'd2, 16'hF000, ev(16'hF000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1), "ret");
        add(1, 3'd2, 16'h3123, 37'h0, "reset_in_decode");
        add(0, 3'd0, 16'h3123, 37'h0, "idle_no_cap");
        add(0, 3'd3, 16'h3123, 37'h0, "request_no_cap");
        add(0, 3'd4, 16'hA123, 37'h0, "wait_no_cap");
        add(0, 3'd7, 16'h3123, 37'h0, "done_no_cap");
        add(0, 3'd2, 16'hA5A5, ev(16'hA5A5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "illegal_a");

        foreach (vecs[k]) begin
            cycle(vecs[k].rst, vecs[k].st, vecs[k].instr);
            check(vecs[k].name, observed(), vecs[k].exp);
        end

        for (int n = 0; n < 600; n++) begin
            logic       r;
            logic [2:0] s;
            r = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 1) == 1) ? 3'd2 : 3'($urandom_range(0, 7));
            cycle(r, s, 16'($urandom));
            check("random", observed(), model_out());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
